bram_s2p_arb: RTL and testbench
===============================

Name: bram_s2p_arb

Overview:
- Round-robin arbiter sharing one 40-bit x 512 simple-dual-port BRAM wrapper between NUM_REQ requesters.
- Write port and read port are arbitrated independently, so one write and one read can issue in the same cycle.
- Tracks read latency and routes returned data to the originating requester.
- Handles the wrapper's write-enable skew: wen is registered, waddr/din are not.
- Prevents read-after-write hazards.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- AW, 9, address width.
- DW, 40, data width.
- RD_LAT, 2, cycles from bram_raddr presented to bram_dout valid (BRAM register + wrapper dout register).
- WEN_SKEW, 1, cycles the wrapper delays wen relative to waddr/din.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wr_req  in  NUM_REQ  per-requester write request, held until granted
- wr_addr  in  NUM_REQ*AW  per-requester write address
- wr_data  in  NUM_REQ*DW  per-requester write data
- wr_gnt  out  NUM_REQ  one-hot write grant, single-cycle pulse
- rd_req  in  NUM_REQ  per-requester read request, held until granted
- rd_addr  in  NUM_REQ*AW  per-requester read address
- rd_gnt  out  NUM_REQ  one-hot read grant, single-cycle pulse
- rd_valid  out  NUM_REQ  one-hot, asserted for the cycle rd_data belongs to that requester
- rd_data  out  DW  returned read data, shared by all requesters
- bram_wen  out  1  to wrapper wen
- bram_waddr  out  AW  to wrapper waddr
- bram_din  out  DW  to wrapper din
- bram_raddr  out  AW  to wrapper raddr
- bram_dout  in  DW  from wrapper dout

Behaviour:
- Reset values: all outputs 0; both round-robin pointers = 0; read tag pipeline cleared.
- Reset is asynchronous, active-low. Asserting it mid-operation drops in-flight reads: no rd_valid is produced for them. A write whose wen already reached the wrapper is not cancelled.
- Write arbitration:
  - Each cycle, grant the first asserted wr_req at or after wr_ptr (cyclic order).
  - Grant pulses wr_gnt[i] for 1 cycle; requester i samples the grant and may drop or change its request on the next cycle.
  - wr_ptr advances to i+1 mod NUM_REQ only on a grant.
- Write issue (cycle T = grant cycle):
  - bram_wen = 1 in cycle T.
  - Winner's addr/data are captured into a WEN_SKEW-deep delay line; bram_waddr/bram_din present them in cycle T+WEN_SKEW.
  - With WEN_SKEW=0, wen/addr/data are all driven in cycle T.
  - bram_waddr/bram_din hold their last value when no write is in flight.
  - A write counts as committed at the end of T+WEN_SKEW.
- Back-to-back writes: one grant per cycle is sustained. The delay line carries a different addr/data each cycle.
- Read arbitration: same round-robin scheme on rd_req/rd_ptr, independent of the write side. bram_raddr = winner's address in the grant cycle R.
- Read return:
  - A tag (valid bit + requester index) shifts through an RD_LAT-deep pipeline.
  - At R+RD_LAT: rd_valid[tag] = 1 and rd_data = bram_dout.
  - Up to RD_LAT reads are in flight, one issued per cycle.
  - rd_data holds its last value when rd_valid is 0.
- Hazard (macro absent):
  - A read candidate whose address matches an uncommitted write (granted, not yet committed, including one granted the same cycle) is masked from that cycle's read arbitration.
  - Other requesters may win instead; rd_ptr is not advanced for the masked one.
- Simultaneous wr_req and rd_req from the same requester are legal and handled independently.
- Requesters with no pending request never receive a grant.
- Address wrap is not applicable: addresses are used as given, range 0..511.

Optional Feature:
- Macro BRAM_ARB_FWD_EN.
- Defined:
  - A read hitting an uncommitted write is not stalled; it is granted normally.
  - Its tag records a forward flag and the pending write data (youngest matching write wins).
  - At return, rd_data = the forwarded data instead of bram_dout; latency is unchanged at RD_LAT.
- Undefined: the stall behaviour above applies, and no forwarding logic is present.

Decomposition:
- Package bram_arb_pkg holds:
  - the AW/DW defaults;
  - the rd_tag_t struct (valid, req index, and under BRAM_ARB_FWD_EN: fwd flag and fwd data);
  - the function rr_pick(req, ptr), returning the one-hot grant.
- One sub-module, bram_arb_rr: a round-robin arbiter holding a pointer, instantiated twice (write side and read side).

Test Plan:
- Reset low for 3 cycles, release, no requests -> all outputs 0, bram_wen 0 for 10 cycles.
- Req0 writes addr 5 data 0xAB_CDEF_0123 at cycle T -> wr_gnt[0] in T, bram_wen=1 in T, bram_waddr=5 and bram_din=0xAB_CDEF_0123 in T+1. Req1 reads addr 5 three cycles later -> rd_valid[1] two cycles after its grant with rd_data=0xAB_CDEF_0123.
- Both requesters hold wr_req continuously for 8 cycles -> grants alternate 0,1,0,1,... with no idle cycle; 8 distinct addresses are written.
- Req0 writes addr 7 (data 0x11) and req1 reads addr 7 in the same cycle, macro absent -> read grant is delayed until the write commits, and the return is 0x11. Macro defined -> read is granted the same cycle and the return is 0x11 at RD_LAT.
- Issue reads from req0 then req1 on consecutive cycles to addrs 1 and 2 -> rd_valid[0] then rd_valid[1] on consecutive cycles with the correct data.
- Assert reset one cycle after a read grant -> no rd_valid appears; after release, pointers are 0 and req0 wins first.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the bram_s2p_arb block.
// The read tag gains forwarding fields when BRAM_ARB_FWD_EN is defined.
package bram_arb_pkg;
   localparam int AW_DEF  = 9;
   localparam int DW_DEF  = 40;
   localparam int MAX_REQ = 4;
   localparam int IDX_W   = 2;

   typedef struct packed {
      logic              valid;
      logic [IDX_W-1:0]  idx;
`ifdef BRAM_ARB_FWD_EN
      logic              fwd;
      logic [DW_DEF-1:0] fwd_data;
`endif
   } rd_tag_t;

   // One-hot grant for the first asserted request at or after ptr, cyclic over n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [IDX_W-1:0]   ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] gnt;
      logic               found;
      logic [IDX_W-1:0]   idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % n);
         if (k < n && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction
endpackage

// File: rtl/bram_arb_rr.sv
// Round-robin arbiter: combinational grant, pointer moves past the winner on a grant.
module bram_arb_rr
   import bram_arb_pkg::*;
#(
   parameter int N = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx
);
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [MAX_REQ-1:0] req_ext, pick;

   always_comb begin
      req_ext        = '0;
      // nothing is granted while the block is held in reset
      req_ext[N-1:0] = req & {N{reset}};
      pick           = rr_pick(req_ext, ptr_q, N);
      gnt            = pick[N-1:0];
      gnt_vld        = |pick;
      gnt_idx        = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (pick[i]) gnt_idx = IDX_W'(i);
      end
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/bram_s2p_arb.sv
// Shares one simple-dual-port BRAM wrapper between NUM_REQ requesters with independent
// write/read round-robin arbitration. BRAM_ARB_FWD_EN: forward pending writes instead of stalling.
module bram_s2p_arb
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int RD_LAT   = 2,
   parameter int WEN_SKEW = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    wr_req,
   input  logic [NUM_REQ*AW-1:0] wr_addr,
   input  logic [NUM_REQ*DW-1:0] wr_data,
   output logic [NUM_REQ-1:0]    wr_gnt,
   input  logic [NUM_REQ-1:0]    rd_req,
   input  logic [NUM_REQ*AW-1:0] rd_addr,
   output logic [NUM_REQ-1:0]    rd_gnt,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic [DW-1:0]         rd_data,
   output logic                  bram_wen,
   output logic [AW-1:0]         bram_waddr,
   output logic [DW-1:0]         bram_din,
   output logic [AW-1:0]         bram_raddr,
   input  logic [DW-1:0]         bram_dout
);
   localparam int SK = (WEN_SKEW == 0) ? 1 : WEN_SKEW;

   logic               wr_vld, rd_vld;
   logic [IDX_W-1:0]   wr_idx, rd_idx;
   logic [AW-1:0]      wr_addr_sel, rd_addr_sel;
   logic [DW-1:0]      wr_data_sel;
   logic [NUM_REQ-1:0] rd_cand;

   logic               wq_vld_q  [SK];
   logic               wq_vld_d  [SK];
   logic [AW-1:0]      wq_addr_q [SK];
   logic [AW-1:0]      wq_addr_d [SK];
   logic [DW-1:0]      wq_data_q [SK];
   logic [DW-1:0]      wq_data_d [SK];
   logic [AW-1:0]      raddr_q, raddr_d;
   logic [DW-1:0]      rd_data_q, rd_data_d;
   rd_tag_t            tag_q [RD_LAT];
   rd_tag_t            tag_d [RD_LAT];
   rd_tag_t            tag_new, tag_out;

   bram_arb_rr #(.N(NUM_REQ)) u_wr_rr (
      .clk(clk), .reset(reset), .req(wr_req),
      .gnt(wr_gnt), .gnt_vld(wr_vld), .gnt_idx(wr_idx)
   );

   bram_arb_rr #(.N(NUM_REQ)) u_rd_rr (
      .clk(clk), .reset(reset), .req(rd_cand),
      .gnt(rd_gnt), .gnt_vld(rd_vld), .gnt_idx(rd_idx)
   );

   always_comb begin
      wr_addr_sel = '0;
      wr_data_sel = '0;
      rd_addr_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_idx == IDX_W'(i)) begin
            wr_addr_sel = wr_addr[i*AW +: AW];
            wr_data_sel = wr_data[i*DW +: DW];
         end
         if (rd_idx == IDX_W'(i)) rd_addr_sel = rd_addr[i*AW +: AW];
      end
   end

   // Stage addr/data only load behind a live write so the wrapper sees held values when idle.
   always_comb begin
      wq_vld_d[0]  = wr_vld && (WEN_SKEW != 0);
      wq_addr_d[0] = wr_vld ? wr_addr_sel : wq_addr_q[0];
      wq_data_d[0] = wr_vld ? wr_data_sel : wq_data_q[0];
      for (int k = 1; k < SK; k++) begin
         wq_vld_d[k]  = wq_vld_q[k-1];
         wq_addr_d[k] = wq_vld_q[k-1] ? wq_addr_q[k-1] : wq_addr_q[k];
         wq_data_d[k] = wq_vld_q[k-1] ? wq_data_q[k-1] : wq_data_q[k];
      end
   end

   assign bram_wen   = wr_vld;
   assign bram_waddr = (WEN_SKEW == 0 && wr_vld) ? wr_addr_sel : wq_addr_q[SK-1];
   assign bram_din   = (WEN_SKEW == 0 && wr_vld) ? wr_data_sel : wq_data_q[SK-1];
   assign bram_raddr = rd_vld ? rd_addr_sel : raddr_q;
   assign raddr_d    = bram_raddr;

`ifdef BRAM_ARB_FWD_EN
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;

   assign rd_cand = rd_req;

   // Oldest first so the youngest matching write overrides.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = SK - 1; k >= 0; k--) begin
         if (wq_vld_q[k] && wq_addr_q[k] == rd_addr_sel) begin
            fwd_hit  = 1'b1;
            fwd_data = wq_data_q[k];
         end
      end
      if (wr_vld && wr_addr_sel == rd_addr_sel) begin
         fwd_hit  = 1'b1;
         fwd_data = wr_data_sel;
      end
   end
`else
   logic [NUM_REQ-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_vld && wr_addr_sel == rd_addr[i*AW +: AW]) hit[i] = 1'b1;
         for (int k = 0; k < SK; k++) begin
            if (wq_vld_q[k] && wq_addr_q[k] == rd_addr[i*AW +: AW]) hit[i] = 1'b1;
         end
      end
   end

   assign rd_cand = rd_req & ~hit;
`endif

   always_comb begin
      tag_new       = '0;
      tag_new.valid = rd_vld;
      tag_new.idx   = rd_idx;
`ifdef BRAM_ARB_FWD_EN
      tag_new.fwd      = fwd_hit;
      tag_new.fwd_data = fwd_data;
`endif
      tag_d[0] = tag_new;
      for (int k = 1; k < RD_LAT; k++) tag_d[k] = tag_q[k-1];
   end

   assign tag_out = tag_q[RD_LAT-1];

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) rd_valid[i] = tag_out.valid && (tag_out.idx == IDX_W'(i));
      rd_data = rd_data_q;
      if (tag_out.valid) begin
`ifdef BRAM_ARB_FWD_EN
         rd_data = tag_out.fwd ? tag_out.fwd_data : bram_dout;
`else
         rd_data = bram_dout;
`endif
      end
   end

   assign rd_data_d = rd_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SK; k++) begin
            wq_vld_q[k]  <= 1'b0;
            wq_addr_q[k] <= '0;
            wq_data_q[k] <= '0;
         end
         for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
         raddr_q   <= '0;
         rd_data_q <= '0;
      end else begin
         for (int k = 0; k < SK; k++) begin
            wq_vld_q[k]  <= wq_vld_d[k];
            wq_addr_q[k] <= wq_addr_d[k];
            wq_data_q[k] <= wq_data_d[k];
         end
         for (int k = 0; k < RD_LAT; k++) tag_q[k] <= tag_d[k];
         raddr_q   <= raddr_d;
         rd_data_q <= rd_data_d;
      end
   end
endmodule

// File: tb/tb_bram_s2p_arb.sv
// Bench for bram_s2p_arb: BRAM wrapper model plus a logical-memory reference model.
// Build with BRAM_ARB_FWD_EN defined to exercise forwarding.
module tb_bram_s2p_arb;
   localparam int N        = 2;
   localparam int AW       = 9;
   localparam int DW       = 40;
   localparam int RD_LAT   = 2;
   localparam int WEN_SKEW = 1;
`ifdef BRAM_ARB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
   logic [N*AW-1:0] wr_addr, rd_addr;
   logic [N*DW-1:0] wr_data;
   logic [DW-1:0]   rd_data, bram_din, bram_dout;
   logic            bram_wen;
   logic [AW-1:0]   bram_waddr, bram_raddr;

   always #5 clk = ~clk;

   bram_s2p_arb #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WEN_SKEW(WEN_SKEW)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_din(bram_din),
      .bram_raddr(bram_raddr), .bram_dout(bram_dout)
   );

   // Wrapper model: wen delayed one cycle, two-cycle registered read, read-before-write.
   logic [DW-1:0] mem [512];
   logic          wen_q = 1'b0;
   logic [DW-1:0] rd_stage;
   always @(posedge clk) begin
      wen_q <= bram_wen;
      if (wen_q) mem[bram_waddr] <= bram_din;
      rd_stage  <= mem[bram_raddr];
      bram_dout <= rd_stage;
   end

   typedef struct { int addr; logic [DW-1:0] data; int commit; } pw_t;
   typedef struct { int due; int req; logic [DW-1:0] data; } ret_t;

   logic [DW-1:0] lmem [512];
   pw_t           pend [$];
   ret_t          rets [$];
   int            cyc, wptr, rptr, mode;
   int            n_checks, n_fail;
   logic [AW-1:0] last_raddr, last_waddr;
   logic [DW-1:0] last_din, last_rd;
   bit            wreq [N];
   bit            rreq [N];
   logic [AW-1:0] waddr_r [N];
   logic [AW-1:0] raddr_r [N];
   logic [DW-1:0] wdata_r [N];
   logic [DW-1:0] dut_rd_cap [N];
   int            dut_rv_cyc [N];
   int            rg_cyc [N];
   int            dut_wg_count;
   logic [N-1:0]  dut_wg_last, dut_rg_last;

   function automatic logic [DW-1:0] init_val(input int a);
      return {16'hA5A5, 15'd0, AW'(a)};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit pending_hit(input logic [AW-1:0] a);
      foreach (pend[j]) if (pend[j].addr == int'(a) && pend[j].commit >= cyc) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         wr_req[i]             = wreq[i];
         rd_req[i]             = rreq[i];
         wr_addr[i*AW +: AW]   = waddr_r[i];
         rd_addr[i*AW +: AW]   = raddr_r[i];
         wr_data[i*DW +: DW]   = wdata_r[i];
      end
   endtask

   // One clock: model predicts, outputs are compared at the falling edge.
   task automatic step();
      int           exp_wg, exp_rg, idx;
      logic [N-1:0] wg_v, rg_v, rv_v;
      pw_t          p;
      ret_t         r;
      exp_wg = -1;
      exp_rg = -1;
      apply();
      @(negedge clk);
      if (!reset) begin
         wptr = 0; rptr = 0;
         rets.delete(); pend.delete();
         last_raddr = '0; last_waddr = '0; last_din = '0; last_rd = '0;
         check_val("rst_wr_gnt", wr_gnt, 0);
         check_val("rst_rd_gnt", rd_gnt, 0);
         check_val("rst_rd_valid", rd_valid, 0);
         check_val("rst_rd_data", rd_data, 0);
         check_val("rst_bram_wen", bram_wen, 0);
         check_val("rst_bram_waddr", bram_waddr, 0);
         check_val("rst_bram_din", bram_din, 0);
         check_val("rst_bram_raddr", bram_raddr, 0);
      end else begin
         while (pend.size() > 0 && pend[0].commit < cyc) void'(pend.pop_front());
         for (int k = 0; k < N; k++) begin
            idx = (wptr + k) % N;
            if (exp_wg < 0 && wreq[idx]) exp_wg = idx;
         end
         if (exp_wg >= 0) begin
            wptr = (exp_wg + 1) % N;
            lmem[waddr_r[exp_wg]] = wdata_r[exp_wg];
            p.addr = int'(waddr_r[exp_wg]); p.data = wdata_r[exp_wg]; p.commit = cyc + WEN_SKEW;
            pend.push_back(p);
            $display("cycle %0d: write grant req %0d addr %0d data %h", cyc, exp_wg, waddr_r[exp_wg], wdata_r[exp_wg]);
         end
         for (int k = 0; k < N; k++) begin
            idx = (rptr + k) % N;
            if (exp_rg < 0 && rreq[idx] && (FWD || !pending_hit(raddr_r[idx]))) exp_rg = idx;
         end
         if (exp_rg >= 0) begin
            rptr = (exp_rg + 1) % N;
            r.due = cyc + RD_LAT; r.req = exp_rg; r.data = lmem[raddr_r[exp_rg]];
            rets.push_back(r);
            last_raddr = raddr_r[exp_rg];
            rg_cyc[exp_rg] = cyc;
            $display("cycle %0d: read grant req %0d addr %0d", cyc, exp_rg, raddr_r[exp_rg]);
         end
         wg_v = '0; rg_v = '0; rv_v = '0;
         if (exp_wg >= 0) wg_v[exp_wg] = 1'b1;
         if (exp_rg >= 0) rg_v[exp_rg] = 1'b1;
         check_val("wr_gnt", wr_gnt, wg_v);
         check_val("bram_wen", bram_wen, |wg_v);
         check_val("rd_gnt", rd_gnt, rg_v);
         check_val("bram_raddr", bram_raddr, last_raddr);
         foreach (pend[j]) if (pend[j].commit == cyc) begin
            last_waddr = AW'(pend[j].addr);
            last_din   = pend[j].data;
         end
         check_val("bram_waddr", bram_waddr, last_waddr);
         check_val("bram_din", bram_din, last_din);
         if (rets.size() > 0 && rets[0].due == cyc) begin
            rv_v[rets[0].req] = 1'b1;
            last_rd = rets[0].data;
            $display("cycle %0d: read return req %0d data %h", cyc, rets[0].req, rets[0].data);
            void'(rets.pop_front());
         end
         check_val("rd_valid", rd_valid, rv_v);
         check_val("rd_data", rd_data, last_rd);
      end
      for (int i = 0; i < N; i++) if (rd_valid[i]) begin
         dut_rd_cap[i] = rd_data;
         dut_rv_cyc[i] = cyc;
      end
      if (|wr_gnt) dut_wg_count++;
      dut_wg_last = wr_gnt;
      dut_rg_last = rd_gnt;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_wg >= 0) begin
         wreq[exp_wg] = 1'b0;
         if (mode == 2) begin
            wreq[exp_wg]    = 1'b1;
            waddr_r[exp_wg] = waddr_r[exp_wg] + AW'(N);
            wdata_r[exp_wg] = DW'({$urandom(), $urandom()});
         end
      end
      if (exp_rg >= 0) rreq[exp_rg] = 1'b0;
      if (mode == 1) begin
         for (int i = 0; i < N; i++) begin
            if (!wreq[i] && $urandom_range(0, 1) == 1) begin
               wreq[i]    = 1'b1;
               waddr_r[i] = AW'($urandom_range(0, 15));
               wdata_r[i] = DW'({$urandom(), $urandom()});
            end
            if (!rreq[i] && $urandom_range(0, 1) == 1) begin
               rreq[i]    = 1'b1;
               raddr_r[i] = AW'($urandom_range(0, 15));
            end
         end
      end
   endtask

   int wc;

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; mode = 0; dut_wg_count = 0;
      wptr = 0; rptr = 0;
      last_raddr = '0; last_waddr = '0; last_din = '0; last_rd = '0;
      for (int a = 0; a < 512; a++) begin
         mem[a]  = init_val(a);
         lmem[a] = init_val(a);
      end
      for (int i = 0; i < N; i++) begin
         wreq[i] = 1'b0; rreq[i] = 1'b0;
         waddr_r[i] = '0; raddr_r[i] = '0; wdata_r[i] = '0;
         dut_rd_cap[i] = '0; dut_rv_cyc[i] = 0; rg_cyc[i] = 0;
      end
      apply();
      @(posedge clk);
      #1;
      repeat (2) step();
      reset = 1'b1;
      repeat (10) step();

      // write then read back three cycles later
      wreq[0] = 1'b1; waddr_r[0] = 9'd5; wdata_r[0] = 40'hAB_CDEF_0123;
      repeat (3) step();
      rreq[1] = 1'b1; raddr_r[1] = 9'd5;
      repeat (4) step();
      check_val("t2_rd_data", dut_rd_cap[1], 40'hAB_CDEF_0123);
      check_val("t2_rd_lat", dut_rv_cyc[1] - rg_cyc[1], RD_LAT);

      // back-to-back writes from both requesters
      mode = 2; dut_wg_count = 0;
      wreq[0] = 1'b1; waddr_r[0] = 9'd20; wdata_r[0] = 40'h20;
      wreq[1] = 1'b1; waddr_r[1] = 9'd21; wdata_r[1] = 40'h21;
      repeat (8) step();
      mode = 0;
      wreq[0] = 1'b0; wreq[1] = 1'b0;
      check_val("t3_b2b_grants", dut_wg_count, 8);
      repeat (3) step();

      // read-after-write hazard on the same address in the same cycle
      wreq[0] = 1'b1; waddr_r[0] = 9'd7; wdata_r[0] = 40'h11;
      rreq[1] = 1'b1; raddr_r[1] = 9'd7;
      wc = cyc;
      repeat (6) step();
      check_val("haz_data", dut_rd_cap[1], 40'h11);
      check_val("haz_ret_delay", dut_rv_cyc[1] - wc, FWD ? RD_LAT : RD_LAT + WEN_SKEW + 1);

      // consecutive reads from different requesters
      rreq[0] = 1'b1; raddr_r[0] = 9'd1;
      step();
      rreq[1] = 1'b1; raddr_r[1] = 9'd2;
      repeat (4) step();
      check_val("t5_ret_spacing", dut_rv_cyc[1] - dut_rv_cyc[0], 1);
      check_val("t5_rd1_data", dut_rd_cap[1], init_val(2));

      // reset one cycle after a read grant
      wreq[0] = 1'b1; waddr_r[0] = 9'd30; wdata_r[0] = 40'h3030;
      repeat (4) step();
      rreq[0] = 1'b1; raddr_r[0] = 9'd30;
      step();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      repeat (4) step();
      wreq[0] = 1'b1; waddr_r[0] = 9'd40; wdata_r[0] = 40'h40;
      wreq[1] = 1'b1; waddr_r[1] = 9'd41; wdata_r[1] = 40'h41;
      rreq[0] = 1'b1; raddr_r[0] = 9'd1;
      rreq[1] = 1'b1; raddr_r[1] = 9'd2;
      step();
      check_val("post_rst_wr_first", dut_wg_last, 2'b01);
      check_val("post_rst_rd_first", dut_rg_last, 2'b01);
      repeat (5) step();

      // randomized traffic over a small address window to provoke hazards
      mode = 1;
      repeat (400) step();
      mode = 0;
      for (int i = 0; i < N; i++) begin
         wreq[i] = 1'b0;
         rreq[i] = 1'b0;
      end
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
